// File: rtl/jtsdram_pkg.sv
// Shared constants for the SDRAM test core: checker FSM encoding, the error
// saturation value and the bank count used by both programmer and checker.
package jtsdram_pkg;
  localparam int          BANKS   = 4;
  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } chk_state_t;
endpackage

// File: rtl/jtsdram_errlog.sv
// Error bookkeeping for the read-back checker: saturating mismatch count,
// per-bank failure flags and capture of the first failing word.
module jtsdram_errlog
  import jtsdram_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             mismatch,
  input  logic [1:0]       ba,
  input  logic [AW-1:0]    addr,
  input  logic [15:0]      data,
  output logic [15:0]      err_cnt,
  output logic [BANKS-1:0] bank_bad,
  output logic [1:0]       first_ba,
  output logic [AW-1:0]    first_addr,
  output logic [15:0]      first_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      bank_bad   <= '0;
      first_ba   <= '0;
      first_addr <= '0;
      first_data <= '0;
    end else if (clr) begin
      err_cnt    <= '0;
      bank_bad   <= '0;
      first_ba   <= '0;
      first_addr <= '0;
      first_data <= '0;
    end else if (mismatch) begin
      if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 16'd1;
      bank_bad[ba] <= 1'b1;
      // each mismatch sets a bank flag; all flags clear marks the first one
      if (bank_bad == '0) begin
        first_ba   <= ba;
        first_addr <= addr;
        first_data <= data;
      end
    end
  end

endmodule

// File: rtl/jtsdram_check.sv
// SDRAM read-back verifier: sweeps every word of banks 0-3 through the read
// port, compares against the shared pattern generator and logs mismatches.
module jtsdram_check
  import jtsdram_pkg::*;
#(
  parameter int AW  = 22,
  parameter int TOW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       chk_ba,
  output logic [AW-1:0]    chk_addr,
  input  logic [15:0]      exp_data,
  output logic             sdram_rd,
  output logic [1:0]       sdram_ba,
  output logic [AW-1:0]    sdram_addr,
  input  logic             sdram_ack,
  input  logic             sdram_rdy,
  input  logic [15:0]      sdram_dout,
  output logic [15:0]      err_cnt,
  output logic [BANKS-1:0] bank_bad,
  output logic [1:0]       first_ba,
  output logic [AW-1:0]    first_addr,
  output logic [15:0]      first_data,
  output logic             timeout
);

  chk_state_t      st;
  logic [AW+1:0]   loc;
  logic [TOW-1:0]  to_cnt, to_nxt;
  logic            cmp_en, mismatch, to_hit;

  assign {chk_ba, chk_addr} = loc;
  assign sdram_ba   = chk_ba;
  assign sdram_addr = chk_addr;

  // ack+rdy together in REQ counts as an immediate data beat
  assign cmp_en   = ((st == ST_REQ) && sdram_ack && sdram_rdy) ||
                    ((st == ST_WAIT) && sdram_rdy);
  assign mismatch = cmp_en && (sdram_dout != exp_data);
  assign to_nxt   = to_cnt + TOW'(1);
  assign to_hit   = (to_nxt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sdram_rd <= 1'b0;
      timeout  <= 1'b0;
      loc      <= '0;
      to_cnt   <= '0;
    end else if (start) begin
      st       <= ST_REQ;
      busy     <= 1'b1;
      done     <= 1'b0;
      sdram_rd <= 1'b1;
      timeout  <= 1'b0;
      loc      <= '0;
      to_cnt   <= '0;
    end else begin
      case (st)
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_rd <= 1'b0;
            to_cnt   <= '0;
            st       <= sdram_rdy ? ST_NEXT : ST_WAIT;
          end else if (to_hit) begin
            timeout  <= 1'b1;
            sdram_rd <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            st       <= ST_DONE;
          end else begin
            to_cnt <= to_nxt;
          end
        end
        ST_WAIT: begin
          if (sdram_rdy) begin
            st <= ST_NEXT;
          end else if (to_hit) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            st      <= ST_DONE;
          end else begin
            to_cnt <= to_nxt;
          end
        end
        ST_NEXT: begin
          loc    <= loc + (AW+2)'(1);
          to_cnt <= '0;
          if (&loc) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= ST_DONE;
          end else begin
            sdram_rd <= 1'b1;
            st       <= ST_REQ;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: st <= ST_IDLE;
      endcase
    end
  end

  jtsdram_errlog #(.AW(AW)) u_errlog (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .mismatch   (mismatch),
    .ba         (chk_ba),
    .addr       (chk_addr),
    .data       (sdram_dout),
    .err_cnt    (err_cnt),
    .bank_bad   (bank_bad),
    .first_ba   (first_ba),
    .first_addr (first_addr),
    .first_data (first_data)
  );

endmodule

// File: tb/tb_jtsdram_check.sv
// Directed bench for jtsdram_check (AW=4, TOW=4) with a behavioural SDRAM
// model, plus a standalone errlog instance for the 16-bit saturation case.
module tb_jtsdram_check;
  localparam int AW  = 4;
  localparam int TOW = 4;
  localparam int M_NORM = 0, M_CORR = 1, M_INV = 2, M_NORDY = 3, M_SAME = 4, M_STRAY = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, sdram_rd, timeout;
  logic [1:0]    chk_ba, sdram_ba, first_ba;
  logic [AW-1:0] chk_addr, sdram_addr, first_addr;
  logic [15:0]   exp_data, sdram_dout, err_cnt, first_data;
  logic          sdram_ack, sdram_rdy;
  logic [3:0]    bank_bad;

  logic          l_clr, l_mis;
  logic [1:0]    l_ba, l_fba;
  logic [AW-1:0] l_addr, l_faddr;
  logic [15:0]   l_data, l_err, l_fdata;
  logic [3:0]    l_bad;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = M_NORM;
  int nreads = 0;
  int ack_edge = 0;
  logic rd_after_ack = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] word(input logic [1:0] ba, input logic [AW-1:0] a);
    return {4'hC, ba, a, ba, a};
  endfunction

  assign exp_data = word(chk_ba, chk_addr);

  jtsdram_check #(.AW(AW), .TOW(TOW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .chk_ba(chk_ba), .chk_addr(chk_addr), .exp_data(exp_data),
    .sdram_rd(sdram_rd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout),
    .err_cnt(err_cnt), .bank_bad(bank_bad), .first_ba(first_ba),
    .first_addr(first_addr), .first_data(first_data), .timeout(timeout)
  );

  jtsdram_errlog #(.AW(AW)) u_log (
    .clk(clk), .rst(rst), .clr(l_clr), .mismatch(l_mis), .ba(l_ba),
    .addr(l_addr), .data(l_data), .err_cnt(l_err), .bank_bad(l_bad),
    .first_ba(l_fba), .first_addr(l_faddr), .first_data(l_fdata)
  );

  function automatic logic [15:0] resp(input logic [1:0] ba, input logic [AW-1:0] a);
    logic [15:0] w;
    w = word(ba, a);
    if (mode == M_INV) return ~w;
    if (mode == M_CORR && ((ba == 2'd2 && a == 4'd5) || (ba == 2'd3 && a == 4'd0)))
      return w ^ 16'h00FF;
    return w;
  endfunction

  // SDRAM model: ack one cycle into the request, data two cycles after ack
  initial begin
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
    forever begin
      @(posedge clk); #1;
      sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
      if (sdram_rd) begin
        if (mode == M_SAME) begin
          sdram_ack = 1'b1; sdram_rdy = 1'b1;
          sdram_dout = word(sdram_ba, sdram_addr); nreads++;
        end else if (mode == M_STRAY) begin
          sdram_rdy = 1'b1; sdram_dout = ~word(sdram_ba, sdram_addr);
          @(posedge clk); #1;
          sdram_ack = 1'b1; sdram_rdy = 1'b1;
          sdram_dout = word(sdram_ba, sdram_addr); nreads++;
        end else begin
          @(posedge clk); #1;
          sdram_ack = 1'b1;
          @(posedge clk); #1;
          sdram_ack = 1'b0; ack_edge = cyc; rd_after_ack = sdram_rd;
          if (!(mode == M_NORDY && sdram_ba == 2'd0 && sdram_addr == 4'd7)) begin
            @(posedge clk); #1;
            sdram_rdy = 1'b1; sdram_dout = resp(sdram_ba, sdram_addr); nreads++;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(output int at);
    start = 1'b1; tick(1); start = 1'b0; at = cyc;
  endtask

  task automatic wait_done(input int lim, output int at);
    int n;
    n = 0;
    while (done !== 1'b1 && n < lim) begin @(posedge clk); #1; n++; end
    at = cyc;
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int s, d, n0;
    rst = 1'b1; start = 1'b0;
    l_clr = 1'b0; l_mis = 1'b0; l_ba = '0; l_addr = '0; l_data = '0;
    tick(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd", {31'd0, sdram_rd}, 0);
    chk("rst_err", {16'd0, err_cnt}, 0);
    chk("rst_loc", {26'd0, chk_ba, chk_addr}, 0);
    rst = 1'b0;
    tick(2);

    // clean sweep
    mode = M_NORM; n0 = nreads;
    pulse_start(s);
    chk("start_rd", {31'd0, sdram_rd}, 1);
    chk("start_busy", {31'd0, busy}, 1);
    wait_done(2000, d);
    chk("clean_reads", nreads - n0, 64);
    chk("clean_err", {16'd0, err_cnt}, 0);
    chk("clean_bad", {28'd0, bank_bad}, 0);
    chk("clean_to", {31'd0, timeout}, 0);
    chk("clean_busy", {31'd0, busy}, 0);
    chk("clean_wrap", {26'd0, chk_ba, chk_addr}, 0);

    // two corrupted words: ba2/5 then ba3/0
    mode = M_CORR;
    pulse_start(s);
    wait_done(2000, d);
    chk("corr_err", {16'd0, err_cnt}, 2);
    chk("corr_bad", {28'd0, bank_bad}, 32'h0000_000C);
    chk("corr_fba", {30'd0, first_ba}, 2);
    chk("corr_faddr", {28'd0, first_addr}, 5);
    chk("corr_fdata", {16'd0, first_data}, 32'h0000_C99A);

    // all words wrong; restart after three errors
    mode = M_INV;
    pulse_start(s);
    for (int i = 0; i < 200 && err_cnt != 16'd3; i++) tick(1);
    chk("inv_err3", {16'd0, err_cnt}, 3);
    pulse_start(s);
    chk("restart_err", {16'd0, err_cnt}, 0);
    chk("restart_bad", {28'd0, bank_bad}, 0);
    chk("restart_loc", {26'd0, chk_ba, chk_addr}, 0);
    chk("restart_busy", {31'd0, busy}, 1);
    wait_done(2000, d);
    chk("inv_err", {16'd0, err_cnt}, 64);
    chk("inv_bad", {28'd0, bank_bad}, 32'h0000_000F);
    chk("inv_fdata", {16'd0, first_data}, 32'h0000_3FFF);

    // ack and rdy together: two cycles per word
    mode = M_SAME; n0 = nreads;
    pulse_start(s);
    wait_done(1000, d);
    chk("same_cycles", d - s, 128);
    chk("same_reads", nreads - n0, 64);
    chk("same_err", {16'd0, err_cnt}, 0);

    // stray rdy in REQ carries a wrong word and must be ignored
    mode = M_STRAY; n0 = nreads;
    pulse_start(s);
    wait_done(1000, d);
    chk("stray_cycles", d - s, 192);
    chk("stray_reads", nreads - n0, 64);
    chk("stray_err", {16'd0, err_cnt}, 0);

    // address 7 acked, never answered
    mode = M_NORDY;
    pulse_start(s);
    wait_done(500, d);
    chk("to_flag", {31'd0, timeout}, 1);
    chk("to_latency", d - ack_edge, 15);
    chk("to_rd_fall", {31'd0, rd_after_ack}, 0);
    chk("to_busy", {31'd0, busy}, 0);
    chk("to_rd", {31'd0, sdram_rd}, 0);
    chk("to_addr", {26'd0, chk_ba, chk_addr}, 7);
    chk("to_err", {16'd0, err_cnt}, 0);

    // asynchronous reset mid-sweep with errors logged
    mode = M_INV;
    pulse_start(s);
    tick(30);
    #3 rst = 1'b1;
    #1;
    chk("arst_err", {16'd0, err_cnt}, 0);
    chk("arst_bad", {28'd0, bank_bad}, 0);
    chk("arst_fdata", {16'd0, first_data}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_rd", {31'd0, sdram_rd}, 0);
    chk("arst_loc", {26'd0, chk_ba, chk_addr}, 0);
    mode = M_NORM;
    tick(2);
    rst = 1'b0;
    tick(2);

    // 16-bit saturation on the error logger alone
    l_clr = 1'b1; tick(1); l_clr = 1'b0;
    chk("log_clr", {16'd0, l_err}, 0);
    for (int i = 0; i < 65538; i++) begin
      l_mis = 1'b1; l_ba = i[1:0]; l_addr = AW'(i + 3); l_data = 16'h1234 ^ 16'(i);
      tick(1);
      if (i == 65533) chk("log_fffe", {16'd0, l_err}, 32'h0000_FFFE);
    end
    l_mis = 1'b0;
    tick(1);
    chk("log_sat", {16'd0, l_err}, 32'h0000_FFFF);
    chk("log_bad", {28'd0, l_bad}, 32'h0000_000F);
    chk("log_fba", {30'd0, l_fba}, 0);
    chk("log_faddr", {28'd0, l_faddr}, 3);
    chk("log_fdata", {16'd0, l_fdata}, 32'h0000_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
